// File: rtl/div_pkg.sv
// Shared definitions for the AXI-Stream restoring divider: operand width,
// fixed end-to-end latency, controller states and a magnitude helper.
package div_pkg;

    localparam int DIV_W       = 32;
    localparam int DIV_LATENCY = 34;

    // Most negative two's-complement value, the only dividend that can overflow
    localparam logic [DIV_W-1:0] DIV_INT_MIN = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Absolute value when interpreted as signed, pass-through otherwise.
    // The magnitude of DIV_INT_MIN is still representable as an unsigned word.
    function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v,
                                                 input logic             is_signed);
        return (is_signed && v[DIV_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    // Trial subtraction; the restored result always fits in W bits because the
    // incoming remainder is strictly smaller than the divisor
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[W-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[W-1:0];
    end

endmodule

// File: rtl/div_axis_core.sv
// AXI-Stream divider core: collects a dividend and a divisor on independent
// channels, runs 32 restoring steps on the magnitudes, applies sign and
// special-case correction, then pulses a single result beat.
module div_axis_core
    import div_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [DIV_W-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    output logic [2*DIV_W-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);

    div_state_e         state_q, state_d;
    logic               dvd_cap_q, dvd_cap_d;
    logic               dvs_cap_q, dvs_cap_d;
    logic [DIV_W-1:0]   dvd_raw_q, dvd_raw_d;
    logic [DIV_W-1:0]   dvs_raw_q, dvs_raw_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [DIV_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   dvs_mag_q, dvs_mag_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*DIV_W-1:0] dout_q, dout_d;
    logic               tvalid_q, tvalid_d;

    logic               dvd_fire;
    logic               dvs_fire;
    logic               step_bit;
    logic [DIV_W-1:0]   step_rem;
    logic               dvd_neg;
    logic               dvs_neg;
    logic               div_zero;
    logic               overflow;
    logic [DIV_W-1:0]   fix_quo;
    logic [DIV_W-1:0]   fix_rem;

    assign s_axis_dividend_tready = (state_q == IDLE) && !dvd_cap_q;
    assign s_axis_divisor_tready  = (state_q == IDLE) && !dvs_cap_q;
    assign dvd_fire               = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign dvs_fire               = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = tvalid_q;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // step and the new quotient bit enters at the LSB
    div_step #(
        .W(DIV_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[DIV_W-1]),
        .divisor (dvs_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Turn the magnitude result into the final quotient/remainder, overriding
    // it for division by zero and for the single signed overflow case
    always_comb begin
        dvd_neg  = SIGNED && dvd_raw_q[DIV_W-1];
        dvs_neg  = SIGNED && dvs_raw_q[DIV_W-1];
        div_zero = (dvs_raw_q == '0);
        overflow = SIGNED && (dvd_raw_q == DIV_INT_MIN) && (dvs_raw_q == '1);
        fix_quo  = quo_q;
        fix_rem  = rem_q;
        if (div_zero) begin
            fix_quo = dvd_neg ? DIV_W'(1) : '1;
            fix_rem = dvd_raw_q;
        end else if (overflow) begin
            fix_quo = DIV_INT_MIN;
            fix_rem = '0;
        end else begin
            fix_quo = (dvd_neg ^ dvs_neg) ? -quo_q : quo_q;
            fix_rem = dvd_neg ? -rem_q : rem_q;
        end
    end

    // Controller: operand capture, 32 iteration steps, correction, result beat
    always_comb begin
        state_d   = state_q;
        dvd_cap_d = dvd_cap_q;
        dvs_cap_d = dvs_cap_q;
        dvd_raw_d = dvd_raw_q;
        dvs_raw_d = dvs_raw_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_mag_d = dvs_mag_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        tvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dvd_fire) begin
                    dvd_raw_d = s_axis_dividend_tdata;
                    dvd_cap_d = 1'b1;
                end
                if (dvs_fire) begin
                    dvs_raw_d = s_axis_divisor_tdata;
                    dvs_cap_d = 1'b1;
                end
                if (dvd_cap_d && dvs_cap_d) begin
                    state_d   = CALC;
                    dvd_cap_d = 1'b0;
                    dvs_cap_d = 1'b0;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = div_mag(dvd_raw_d, SIGNED);
                    dvs_mag_d = div_mag(dvs_raw_d, SIGNED);
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[DIV_W-2:0], step_bit};
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                dout_d   = {fix_quo, fix_rem};
                tvalid_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_cap_q <= 1'b0;
            dvs_cap_q <= 1'b0;
            dvd_raw_q <= '0;
            dvs_raw_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_mag_q <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_cap_q <= dvd_cap_d;
            dvs_cap_q <= dvs_cap_d;
            dvd_raw_q <= dvd_raw_d;
            dvs_raw_q <= dvs_raw_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_mag_q <= dvs_mag_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            tvalid_q  <= tvalid_d;
        end
    end

endmodule

// File: doc/div_axis_core.md
DIV_AXIS_CORE -- requirements
Module: div_axis_core

Interface
REQ-001 SHALL have parameter: SIGNED, 0, 1 = two's-complement division, 0 = unsigned.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: s_axis_dividend_tdata  input  32  dividend.
REQ-005 SHALL have port: s_axis_dividend_tvalid  input  1  dividend offered.
REQ-006 SHALL have port: s_axis_dividend_tready  output  1  dividend can be accepted.
REQ-007 SHALL have port: s_axis_divisor_tdata  input  32  divisor.
REQ-008 SHALL have port: s_axis_divisor_tvalid  input  1  divisor offered.
REQ-009 SHALL have port: s_axis_divisor_tready  output  1  divisor can be accepted.
REQ-010 SHALL have port: m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}.
REQ-011 SHALL have port: m_axis_dout_tvalid  output  1  result valid, one-cycle pulse, no backpressure.

Function
REQ-012 SHALL use states IDLE, CALC, FIX, DONE.
REQ-013 In IDLE, each tready SHALL be high only while its operand is not yet captured; in CALC/FIX/DONE both tready SHALL be low.
REQ-014 Operand SHALL be captured on an edge where its tvalid and tready are both high; the two channels are independent and may complete in the same or different cycles.
REQ-015 On the edge where the second operand is captured (edge k), SHALL enter CALC and clear both captured flags.
REQ-016 CALC SHALL run exactly 32 cycles (k+1..k+32) of radix-2 restoring division on magnitudes, one quotient bit per cycle, 5-bit counter 0..31.
REQ-017 FIX (cycle k+33) SHALL apply sign correction and register m_axis_dout_tdata.
REQ-018 DONE (cycle k+34) SHALL drive m_axis_dout_tvalid=1 for exactly that cycle, then return to IDLE.
REQ-019 Latency SHALL be fixed at 34 cycles from edge k to tvalid, independent of operand values, including the special cases below.
REQ-020 m_axis_dout_tdata SHALL hold its value from FIX until the next FIX or reset.
REQ-021 Signed mode: quotient truncated toward zero; remainder sign equals dividend sign; |remainder| < |divisor|.
REQ-022 Divisor zero, unsigned: quotient 0xFFFFFFFF, remainder = dividend.
REQ-023 Divisor zero, signed: quotient = dividend<0 ? 0x00000001 : 0xFFFFFFFF; remainder = dividend.
REQ-024 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0x00000000.
REQ-025 tvalid presented on a channel already captured SHALL be ignored (tready low); the upstream holds it until completion.

Reset
REQ-026 On rst: state IDLE, captured flags 0, counter 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 0.
REQ-027 rst in any state, including mid-CALC, SHALL abort the operation with no tvalid pulse; both tready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Package div_pkg SHALL hold the state enumeration, DIV_W=32, and DIV_LATENCY=34.
REQ-029 One sub-module div_step SHALL implement a single restoring step (shifted partial remainder, divisor -> next remainder, quotient bit), combinational.
REQ-030 Magnitude conversion, special-case detection and sign fix SHALL reside in div_axis_core.

Verification
REQ-031 SIGNED=0, 100/7 both valid at edge 0 -> tvalid at cycle 34 only, tdata 0x0000000E_00000002.
REQ-032 SIGNED=1, -7/2 (0xFFFFFFF9/0x00000002) -> tdata 0xFFFFFFFD_FFFFFFFF; and 0x80000000/0xFFFFFFFF -> 0x80000000_00000000.
REQ-033 Divisor 0: SIGNED=0 5/0 -> 0xFFFFFFFF_00000005; SIGNED=1 -5/0 -> 0x00000001_FFFFFFFB; latency 34.
REQ-034 Dividend accepted edge 0, divisor tvalid raised at cycle 5 -> divisor_tready high until edge 5, dividend_tready low cycles 1..5, tvalid at cycle 39.
REQ-035 rst asserted at cycle 10 of CALC -> no tvalid ever, tdata 0, both tready 1 after release; new 9/3 then yields 0x00000003_00000000 at 34 cycles.
REQ-036 Back-to-back: second operand pair held valid during busy -> accepted in first IDLE cycle after DONE; tready never high in CALC/FIX/DONE.
